// File: rtl/weight_loader_pkg.sv
// Shared constants, state encoding and payload types for the kernel weight loader.
package weight_loader_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ROWS   = 5;
  localparam int unsigned COLS   = 5;
  localparam int unsigned CH     = 3;

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned CH_W  = $clog2(CH);

  localparam logic [COLS-1:0] ROW_MASK = {COLS{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [DATA_W-1:0] word_t;

  // One kernel row as staged for the RAM block: [col][ch].
  typedef word_t [COLS-1:0][CH-1:0] row_t;

endpackage

// File: rtl/weight_loader_if.sv
// Valid/ready weight stream between a word source and the loader.
interface weight_loader_if;
  import weight_loader_pkg::*;

  logic  s_valid;
  logic  s_ready;
  word_t s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/weight_row_stage.sv
// Staging register file for one kernel row, written one (col, ch) word at a time.
module weight_row_stage
  import weight_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [COL_W-1:0] col,
  input  logic [CH_W-1:0]  ch,
  input  word_t            data,
  output row_t             row
);

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
    end else if (wr_en) begin
      row[col][ch] <= data;
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Streams a 5x5x3 kernel into the weight RAM block one row per write cycle.
// Optional running checksum of accepted words: define WEIGHT_LOADER_CHKSUM_EN.
module weight_loader
  import weight_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  weight_loader_if.slave    strm,
  output logic [ROW_W-1:0]  addr_write,
  output logic [COLS-1:0]   write_enable,
  output word_t             data_in_0_0,
  output word_t             data_in_0_1,
  output word_t             data_in_0_2,
  output word_t             data_in_1_0,
  output word_t             data_in_1_1,
  output word_t             data_in_1_2,
  output word_t             data_in_2_0,
  output word_t             data_in_2_1,
  output word_t             data_in_2_2,
  output word_t             data_in_3_0,
  output word_t             data_in_3_1,
  output word_t             data_in_3_2,
  output word_t             data_in_4_0,
  output word_t             data_in_4_1,
  output word_t             data_in_4_2,
  output logic              busy,
  output logic              done,
  output logic              weights_valid
`ifdef WEIGHT_LOADER_CHKSUM_EN
  ,
  output logic [DATA_W-1:0] chksum
`endif
);

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [CH_W-1:0]  ch;

  logic             ready_nxt, busy_nxt, done_nxt, valid_nxt;
  logic [COLS-1:0]  we_nxt;
  logic [ROW_W-1:0] addr_nxt;
  row_t             stage;

  logic accept, take, last_word, start_go, abort_act;

  // Abort beats a concurrent handshake, so a word is only kept when abort is low.
  assign accept    = strm.s_valid & strm.s_ready;
  assign take      = accept & ~abort;
  assign last_word = (col == COL_W'(COLS - 1)) & (ch == CH_W'(CH - 1));
  assign start_go  = (state == IDLE) & start & ~abort;
  assign abort_act = abort & (state != IDLE);

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      row           <= '0;
      col           <= '0;
      ch            <= '0;
      strm.s_ready  <= 1'b0;
      write_enable  <= '0;
      addr_write    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      weights_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      strm.s_ready  <= ready_nxt;
      write_enable  <= we_nxt;
      addr_write    <= addr_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      weights_valid <= valid_nxt;
      if (start_go || abort_act) begin
        row <= '0;
        col <= '0;
        ch  <= '0;
      end else if (take) begin
        if (ch == CH_W'(CH - 1)) begin
          ch  <= '0;
          col <= last_word ? '0 : col + COL_W'(1);
        end else begin
          ch  <= ch + CH_W'(1);
        end
      end else if (state == WRITE) begin
        row <= (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = FILL;
        FILL:    if (take && last_word) state_nxt = WRITE;
        WRITE:   state_nxt = (row == ROW_W'(ROWS - 1)) ? DONE : FILL;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output values for the coming state, registered above.
  always_comb begin
    ready_nxt = 1'b0;
    we_nxt    = '0;
    addr_nxt  = addr_write;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    valid_nxt = weights_valid;
    if (start_go || abort_act) valid_nxt = 1'b0;
    case (state_nxt)
      FILL: begin
        ready_nxt = 1'b1;
        busy_nxt  = 1'b1;
      end
      WRITE: begin
        we_nxt   = ROW_MASK;
        addr_nxt = row;
        busy_nxt = 1'b1;
      end
      DONE: begin
        busy_nxt  = 1'b1;
        done_nxt  = 1'b1;
        valid_nxt = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef WEIGHT_LOADER_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || start_go || abort_act) begin
      chksum <= '0;
    end else if (take) begin
      chksum <= chksum + strm.s_data;
    end
  end
`endif

  weight_row_stage u_stage (
    .clk   (clk),
    .rst   (rst),
    .wr_en (take),
    .col   (col),
    .ch    (ch),
    .data  (strm.s_data),
    .row   (stage)
  );

  assign data_in_0_0 = stage[0][0];
  assign data_in_0_1 = stage[0][1];
  assign data_in_0_2 = stage[0][2];
  assign data_in_1_0 = stage[1][0];
  assign data_in_1_1 = stage[1][1];
  assign data_in_1_2 = stage[1][2];
  assign data_in_2_0 = stage[2][0];
  assign data_in_2_1 = stage[2][1];
  assign data_in_2_2 = stage[2][2];
  assign data_in_3_0 = stage[3][0];
  assign data_in_3_1 = stage[3][1];
  assign data_in_3_2 = stage[3][2];
  assign data_in_4_0 = stage[4][0];
  assign data_in_4_1 = stage[4][1];
  assign data_in_4_2 = stage[4][2];

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: expected rows queued at drive time, checked against captured strobes.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [2:0]  addr_write;
  logic [4:0]  write_enable;
  logic        busy, done, weights_valid;
  logic [15:0] dout [15];
`ifdef WEIGHT_LOADER_CHKSUM_EN
  logic [15:0] chksum;
`endif

  weight_loader_if bus ();

  weight_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .strm          (bus),
    .addr_write    (addr_write),
    .write_enable  (write_enable),
    .data_in_0_0   (dout[0]),
    .data_in_0_1   (dout[1]),
    .data_in_0_2   (dout[2]),
    .data_in_1_0   (dout[3]),
    .data_in_1_1   (dout[4]),
    .data_in_1_2   (dout[5]),
    .data_in_2_0   (dout[6]),
    .data_in_2_1   (dout[7]),
    .data_in_2_2   (dout[8]),
    .data_in_3_0   (dout[9]),
    .data_in_3_1   (dout[10]),
    .data_in_3_2   (dout[11]),
    .data_in_4_0   (dout[12]),
    .data_in_4_1   (dout[13]),
    .data_in_4_2   (dout[14]),
    .busy          (busy),
    .done          (done),
    .weights_valid (weights_valid)
`ifdef WEIGHT_LOADER_CHKSUM_EN
    ,
    .chksum        (chksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]        addr;
    logic [4:0]        we;
    logic              rdy;
    logic [14:0][15:0] w;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs [256];
  int   wr_idx = 0;
  int   rd_idx = 0;
  int   dones  = 0;
  bit   mon_en = 1'b0;
  logic [15:0] row2_d31 = '0;

  int total = 0;
  int bad   = 0;

  // Capture every write strobe and done pulse as the DUT produces it.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done === 1'b1) dones++;
      if (write_enable !== 5'b0 && wr_idx < 256) begin
        rec_t o;
        o.addr = addr_write;
        o.we   = write_enable;
        o.rdy  = bus.s_ready;
        for (int i = 0; i < 15; i++) o.w[i] = dout[i];
        if (addr_write === 3'd2) row2_d31 = dout[10];
        obs[wr_idx] = o;
        wr_idx++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] word_of(input int mode, input int n);
    case (mode)
      0:       return 16'(n);
      1:       return 16'h0101;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic push_exp(input int mode, input int r);
    rec_t e;
    e.addr = 3'(r);
    e.we   = 5'b11111;
    e.rdy  = 1'b0;
    for (int i = 0; i < 15; i++) e.w[i] = word_of(mode, r * 15 + i);
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] d, input bit gaps);
    bit rdy;
    int k;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    rdy = 1'b0;
    k   = 0;
    while (!rdy && k < 100) begin
      @(negedge clk);
      rdy = bus.s_ready;
      @(posedge clk); #1;
      k++;
    end
    total++;
    if (!rdy) begin
      bad++;
      $display("FAIL handshake_timeout word=%0d s_ready=%b required=1", d, bus.s_ready);
    end
  endtask

  task automatic check_writes(input string tag);
    rec_t o, e;
    while (rd_idx < wr_idx) begin
      o = obs[rd_idx];
      rd_idx++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s unexpected_strobe addr=%0d we=%b required=none", tag, o.addr, o.we);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (o.addr !== e.addr) begin
          bad++; $display("FAIL %s addr_write got=%0d required=%0d", tag, o.addr, e.addr);
        end
        total++;
        if (o.we !== e.we) begin
          bad++; $display("FAIL %s write_enable got=%b required=%b", tag, o.we, e.we);
        end
        total++;
        if (o.rdy !== 1'b0) begin
          bad++; $display("FAIL %s s_ready_in_write got=%b required=0", tag, o.rdy);
        end
        for (int i = 0; i < 15; i++) begin
          total++;
          if (o.w[i] !== e.w[i]) begin
            bad++;
            $display("FAIL %s row%0d data_in_%0d_%0d got=%0d required=%0d",
                     tag, e.addr, i / 3, i % 3, o.w[i], e.w[i]);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing_strobes got=%0d_left required=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_load(input string tag, input int mode, input bit gaps, input int start_at);
    int w0, d0;
    logic [15:0] sum;
    w0  = wr_idx;
    d0  = dones;
    sum = '0;
    for (int r = 0; r < 5; r++) push_exp(mode, r);
    pulse_start();
    for (int n = 0; n < 75; n++) begin
      if (n == start_at) begin
        bus.s_valid = 1'b0;
        pulse_start();
      end
      sum = sum + word_of(mode, n);
      push_word(word_of(mode, n), gaps);
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    total++;
    if (write_enable !== 5'b11111 || addr_write !== 3'd4) begin
      bad++;
      $display("FAIL %s last_write_latency we=%b addr=%0d required=11111/4", tag, write_enable, addr_write);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || weights_valid !== 1'b1 || write_enable !== 5'b0) begin
      bad++;
      $display("FAIL %s done_cycle done=%b wv=%b we=%b required=1/1/0", tag, done, weights_valid, write_enable);
    end
`ifdef WEIGHT_LOADER_CHKSUM_EN
    total++;
    if (chksum !== sum) begin
      bad++; $display("FAIL %s chksum got=%h required=%h", tag, chksum, sum);
    end
`endif
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || weights_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s after_done done=%b busy=%b wv=%b required=0/0/1", tag, done, busy, weights_valid);
    end
    total++;
    if (wr_idx - w0 != 5) begin
      bad++; $display("FAIL %s strobe_count got=%0d required=5", tag, wr_idx - w0);
    end
    total++;
    if (dones - d0 != 1) begin
      bad++; $display("FAIL %s done_count got=%0d required=1", tag, dones - d0);
    end
    check_writes(tag);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 15; i++) acc = acc | dout[i];
    total++;
    if (bus.s_ready !== 1'b0 || write_enable !== 5'b0 || addr_write !== 3'd0) begin
      bad++;
      $display("FAIL %s ctrl rdy=%b we=%b addr=%0d required=0/0/0", tag, bus.s_ready, write_enable, addr_write);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || weights_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s status busy=%b done=%b wv=%b required=0/0/0", tag, busy, done, weights_valid);
    end
    total++;
    if (acc !== 16'h0) begin
      bad++; $display("FAIL %s stage_or got=%h required=0000", tag, acc);
    end
`ifdef WEIGHT_LOADER_CHKSUM_EN
    total++;
    if (chksum !== 16'h0) begin
      bad++; $display("FAIL %s chksum got=%h required=0000", tag, chksum);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
  endtask

  task automatic test_full_load();
    run_load("full_load", 0, 1'b0, -1);
    total++;
    if (row2_d31 !== 16'd40) begin
      bad++; $display("FAIL full_load row2_data_in_3_1 got=%0d required=40", row2_d31);
    end
  endtask

  task automatic test_gaps();
    run_load("gaps", 0, 1'b1, -1);
  endtask

  task automatic test_start_in_fill();
    run_load("start_in_fill", 0, 1'b0, 7);
  endtask

  task automatic test_abort();
    int w0, d0;
    w0 = wr_idx;
    d0 = dones;
    push_exp(0, 0);
    pulse_start();
    for (int n = 0; n < 20; n++) push_word(word_of(0, n), 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'd20;
    abort       = 1'b1;
    @(posedge clk); #1;
    abort       = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || bus.s_ready !== 1'b0 || weights_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort state busy=%b rdy=%b wv=%b required=0/0/0", busy, bus.s_ready, weights_valid);
    end
    total++;
    if (dout[5] !== 16'd5) begin
      bad++; $display("FAIL abort word_stored data_in_1_2 got=%0d required=5", dout[5]);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (wr_idx - w0 != 1 || dones - d0 != 0) begin
      bad++;
      $display("FAIL abort counts strobes=%0d dones=%0d required=1/0", wr_idx - w0, dones - d0);
    end
    check_writes("abort");
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || bus.s_ready !== 1'b0) begin
      bad++; $display("FAIL start_abort_idle busy=%b rdy=%b required=0/0", busy, bus.s_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_in_write();
    push_exp(0, 0);
    pulse_start();
    for (int n = 0; n < 15; n++) push_word(word_of(0, n), 1'b0);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (write_enable !== 5'b11111) begin
      bad++; $display("FAIL rst_in_write pre_we got=%b required=11111", write_enable);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst_in_write");
    check_writes("rst_in_write");
    @(posedge clk); #1;
  endtask

  task automatic test_chksum();
    run_load("chksum_0101", 1, 1'b0, -1);
    run_load("chksum_ffff", 2, 1'b1, -1);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_gaps();
    test_start_in_fill();
    test_abort();
    test_start_abort_idle();
    test_rst_in_write();
    test_chksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
